// File: rtl/rw_write_engine.sv
// rw_write_engine: RW write-back stage issuing sized/strobed data-array writes, tracking credits, returning unlocks and finish entries.
// Optional statistics counters are built when RW_WRITE_ENGINE_STATS_EN is defined.

module rw_we_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module rw_write_engine #(
    parameter int LOG_RW_WIDTH     = 2,
    parameter int THREAD_W         = 4,
    parameter int SLOT_W           = 6,
    parameter int WFIFO_LOG_DEPTH  = 1,
    parameter int FINISH_LOG_DEPTH = 1,
    parameter int MAX_OUTSTANDING  = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_is_restore,
    input  logic                         in_wr_en,
    input  logic [31:0]                  in_addr,
    input  logic [2:0]                   in_size,
    input  logic [(8<<LOG_RW_WIDTH)-1:0] in_data,
    input  logic [THREAD_W-1:0]          in_thread,
    input  logic [SLOT_W-1:0]            in_slot,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [31:0]                  waddr,
    output logic [511:0]                 wdata,
    output logic [63:0]                  wstrb,
    output logic [THREAD_W-1:0]          wid,
    input  logic                         bvalid,
    output logic                         bready,
    input  logic [THREAD_W-1:0]          bid,
    output logic                         unlock_valid,
    output logic [THREAD_W-1:0]          unlock_thread,
    output logic                         finish_valid,
    input  logic                         finish_ready,
    output logic [SLOT_W-1:0]            finish_slot,
    output logic                         finish_is_restore,
    output logic [7:0]                   outstanding,
    output logic                         err_misaligned,
    output logic                         err_spurious_b,
    output logic                         err_bad_size
`ifdef RW_WRITE_ENGINE_STATS_EN
    ,
    input  logic [2:0]                   stat_sel,
    output logic [31:0]                  stat_data
`endif
);
    localparam int WF_W = 32 + 512 + 64 + THREAD_W;
    localparam int FF_W = SLOT_W + 1;

    logic                w_task;
    logic                accept;
    logic                push_w;
    logic                imm_req;
    logic                credit_ok;
    logic                b_pop;
    logic                b_live;
    logic                misaligned;
    logic                wf_full, wf_empty;
    logic                ff_full, ff_empty;
    logic                bf_full, bf_empty;
    logic [2:0]          s;
    logic [31:0]         fmt_addr;
    logic [511:0]        fmt_data;
    logic [63:0]         fmt_strb;
    logic [WF_W-1:0]     wf_dout;
    logic [FF_W-1:0]     ff_dout;
    logic [THREAD_W-1:0] bf_dout;

    assign w_task     = in_is_restore | in_wr_en;
    assign credit_ok  = outstanding < 8'(MAX_OUTSTANDING);
    assign in_ready   = rstn & in_valid & ~ff_full & (~w_task | (~wf_full & credit_ok));
    assign accept     = in_ready;
    assign push_w     = accept & w_task;
    assign imm_req    = accept & ~w_task;
    // Immediate unlocks own the unlock port; the B FIFO head waits behind them.
    assign b_pop      = ~imm_req & ~bf_empty;
    assign b_live     = b_pop & (outstanding != 8'd0);
    assign misaligned = |(in_addr & ((32'd1 << in_size) - 32'd1));
    assign bready     = rstn & ~bf_full;

    always_comb begin
        s        = (in_size > 3'(LOG_RW_WIDTH)) ? 3'(LOG_RW_WIDTH) : in_size;
        fmt_addr = in_addr & ~((32'd1 << s) - 32'd1);
        fmt_data = '0;
        fmt_strb = '0;
        for (int i = 0; i < 64; i++) begin
            fmt_data[i*8 +: 8] = 8'(in_data >> (8 * (i & ((1 << s) - 1))));
            fmt_strb[i]        = ((i >> s) == (int'(fmt_addr[5:0]) >> s));
        end
    end

    rw_we_fifo #(.WIDTH(WF_W), .LOG_DEPTH(WFIFO_LOG_DEPTH)) u_wfifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_w),
        .pop   (wready),
        .din   ({fmt_addr, fmt_data, fmt_strb, in_thread}),
        .dout  (wf_dout),
        .full  (wf_full),
        .empty (wf_empty)
    );

    rw_we_fifo #(.WIDTH(FF_W), .LOG_DEPTH(FINISH_LOG_DEPTH)) u_ffifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (accept),
        .pop   (finish_ready),
        .din   ({in_slot, in_is_restore}),
        .dout  (ff_dout),
        .full  (ff_full),
        .empty (ff_empty)
    );

    rw_we_fifo #(.WIDTH(THREAD_W), .LOG_DEPTH(1)) u_bfifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bvalid & bready),
        .pop   (b_pop),
        .din   (bid),
        .dout  (bf_dout),
        .full  (bf_full),
        .empty (bf_empty)
    );

    assign wvalid            = ~wf_empty;
    assign waddr             = wvalid ? wf_dout[WF_W-1 -: 32] : '0;
    assign wdata             = wvalid ? wf_dout[THREAD_W+64 +: 512] : '0;
    assign wstrb             = wvalid ? wf_dout[THREAD_W +: 64] : '0;
    assign wid               = wvalid ? wf_dout[THREAD_W-1:0] : '0;
    assign finish_valid      = ~ff_empty;
    assign finish_slot       = finish_valid ? ff_dout[FF_W-1:1] : '0;
    assign finish_is_restore = finish_valid & ff_dout[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding    <= '0;
            unlock_valid   <= 1'b0;
            unlock_thread  <= '0;
            err_misaligned <= 1'b0;
            err_spurious_b <= 1'b0;
            err_bad_size   <= 1'b0;
        end else begin
            outstanding   <= outstanding + {7'd0, push_w} - {7'd0, b_live};
            unlock_valid  <= imm_req | b_live;
            unlock_thread <= imm_req ? in_thread : (b_live ? bf_dout : '0);
            if (accept && misaligned)                      err_misaligned <= 1'b1;
            if (accept && (in_size > 3'(LOG_RW_WIDTH)))    err_bad_size   <= 1'b1;
            if (b_pop && (outstanding == 8'd0))            err_spurious_b <= 1'b1;
        end
    end

`ifdef RW_WRITE_ENGINE_STATS_EN
    logic [31:0] stat_cnt [6];
    logic [5:0]  stat_inc;

    // Stall causes are exclusive, attributed in finish -> wfifo -> credit order.
    assign stat_inc[0] = accept;
    assign stat_inc[1] = ~in_valid;
    assign stat_inc[2] = in_valid & ~ff_full & w_task & ~wf_full & ~credit_ok;
    assign stat_inc[3] = in_valid & ~ff_full & w_task & wf_full;
    assign stat_inc[4] = in_valid & ff_full;
    assign stat_inc[5] = wvalid & wready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 6; k++) stat_cnt[k] <= '0;
            stat_data <= '0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (stat_inc[k] && (stat_cnt[k] != '1)) stat_cnt[k] <= stat_cnt[k] + 32'd1;
            end
            stat_data <= (stat_sel < 3'd6) ? stat_cnt[stat_sel] : '0;
        end
    end
`endif
endmodule
